// File: rtl/vga_timing.sv
// vga_timing: 1024x768@70 raster timing generator; VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output
`timescale 1ns/1ps
module vga_timing #(
  parameter int HOR_TOTAL       = 1328,
  parameter int HOR_BLANK_START = 1024,
  parameter int HOR_SYNC_START  = 1048,
  parameter int HOR_SYNC_TIME   = 136,
  parameter int VER_TOTAL       = 806,
  parameter int VER_BLANK_START = 768,
  parameter int VER_SYNC_START  = 771,
  parameter int VER_SYNC_TIME   = 6,
  parameter int CNT_W           = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOR_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VER_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLK  = CNT_W'(HOR_BLANK_START);
  localparam logic [CNT_W-1:0] H_SYN0 = CNT_W'(HOR_SYNC_START);
  localparam logic [CNT_W-1:0] H_SYN1 = CNT_W'(HOR_SYNC_START + HOR_SYNC_TIME);
  localparam logic [CNT_W-1:0] V_BLK  = CNT_W'(VER_BLANK_START);
  localparam logic [CNT_W-1:0] V_SYN0 = CNT_W'(VER_SYNC_START);
  localparam logic [CNT_W-1:0] V_SYN1 = CNT_W'(VER_SYNC_START + VER_SYNC_TIME);
  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic h_wrap, v_wrap;
  always_comb begin
    h_wrap        = en && (hcount_q == H_LAST);
    v_wrap        = h_wrap && (vcount_q == V_LAST);
    hcount_d      = en ? (h_wrap ? '0 : hcount_q + 1'b1) : hcount_q;
    vcount_d      = h_wrap ? (v_wrap ? '0 : vcount_q + 1'b1) : vcount_q;
    hblnk_d       = hcount_d >= H_BLK;
    hsync_d       = (hcount_d >= H_SYN0) && (hcount_d < H_SYN1);
    vblnk_d       = vcount_d >= V_BLK;
    vsync_d       = (vcount_d >= V_SYN0) && (vcount_d < V_SYN1);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboarded bench; a full-size instance for horizontal timing and a short-line instance for vertical/frame timing
`timescale 1ns/1ps
module tb_vga_timing;
  typedef struct {
    int h;
    int v;
    int fc;
    bit ls;
    bit fs;
  } st_t;
  typedef struct {
    logic [27:0] m;
    logic [27:0] v;
    logic [15:0] fm;
    logic [15:0] fv;
  } rec_t;
  logic clk = 1'b0, rst_n, en;
  logic [10:0] hc_m, vc_m, hc_v, vc_v;
  logic hs_m, vs_m, hb_m, vb_m, ls_m, fs_m, hs_v, vs_v, hb_v, vb_v, ls_v, fs_v;
  logic [15:0] fc_m, fc_v;
  logic [27:0] obs_m, obs_v;
  int checks = 0, errors = 0;
  st_t m, mv;
  rec_t sb[$];
  always #5 clk = ~clk;
  vga_timing dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(hc_m), .vcount(vc_m),
    .hsync(hs_m), .vsync(vs_m), .hblnk(hb_m), .vblnk(vb_m),
    .line_start(ls_m),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc_m),
`endif
    .frame_start(fs_m)
  );
  vga_timing #(.HOR_TOTAL(8), .HOR_BLANK_START(5), .HOR_SYNC_START(6), .HOR_SYNC_TIME(1)) dut_v (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(hc_v), .vcount(vc_v),
    .hsync(hs_v), .vsync(vs_v), .hblnk(hb_v), .vblnk(vb_v),
    .line_start(ls_v),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fc_v),
`endif
    .frame_start(fs_v)
  );
`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_m = '0;
  assign fc_v = '0;
`endif
  assign obs_m = {hc_m, vc_m, hs_m, vs_m, hb_m, vb_m, ls_m, fs_m};
  assign obs_v = {hc_v, vc_v, hs_v, vs_v, hb_v, vb_v, ls_v, fs_v};
  function automatic st_t adv(st_t s, bit e, int ht, int vt);
    st_t n = s;
    n.ls = 0;
    n.fs = 0;
    if (e) begin
      if (s.h == ht - 1) begin
        n.h  = 0;
        n.ls = 1;
        if (s.v == vt - 1) begin
          n.v  = 0;
          n.fs = 1;
          n.fc = (s.fc + 1) % 65536;
        end else n.v = s.v + 1;
      end else n.h = s.h + 1;
    end
    return n;
  endfunction
  function automatic logic [27:0] pk(st_t s, int hb, int hs, int hst, int vb, int vs, int vst);
    logic [10:0] h = 11'(s.h);
    logic [10:0] v = 11'(s.v);
    return {h, v, (s.h >= hs && s.h < hs + hst), (s.v >= vs && s.v < vs + vst),
            (s.h >= hb), (s.v >= vb), s.ls, s.fs};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit e);
    rec_t r;
    en = e;
    m  = adv(m, e, 1328, 806);
    mv = adv(mv, e, 8, 806);
    r.m  = pk(m, 1024, 1048, 136, 768, 771, 6);
    r.v  = pk(mv, 5, 6, 1, 768, 771, 6);
    r.fm = 16'(m.fc);
    r.fv = 16'(mv.fc);
    sb.push_back(r);
    @(posedge clk);
    #1;
    r = sb.pop_front();
    chk("main_state", obs_m, r.m);
    chk("short_state", obs_v, r.v);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("main_frame_cnt", fc_m, r.fm);
    chk("short_frame_cnt", fc_v, r.fv);
`endif
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    m = '{default: 0};
    mv = '{default: 0};
    #12;
    chk("reset_main", obs_m, 0);
    chk("reset_short", obs_v, 0);
    chk("reset_frame_cnt", fc_v, 0);
    rst_n = 1'b1;
    tick(1);
    chk("first_hcount", hc_m, 1);
    chk("first_vcount", vc_m, 0);
    chk("first_line_start", ls_m, 0);
    for (int i = 0; i < 2000 && m.h != 1327; i++) tick(1);
    chk("end_hblnk", hb_m, 1);
    chk("end_hsync", hs_m, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("hold_hcount", hc_m, 1327);
    end
    tick(1);
    chk("wrap_hcount", hc_m, 0);
    chk("wrap_vcount", vc_m, 1);
    chk("wrap_line_start", ls_m, 1);
    chk("wrap_hblnk", hb_m, 0);
    tick(0);
    chk("pulse_cleared", ls_m, 0);
    chk("pulse_hold_h", hc_m, 0);
    tick(1);
    for (int i = 0; i < 10000 && !mv.fs; i++) tick(1);
    chk("frame_start", fs_v, 1);
    chk("frame_line_start", ls_v, 1);
    chk("frame_vcount", vc_v, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt_one", fc_v, 1);
`endif
    tick(1);
    chk("frame_start_clear", fs_v, 0);
    for (int i = 0; i < 5000 && mv.v != 300; i++) tick(1);
    rst_n = 1'b0;
    #1;
    m = '{default: 0};
    mv = '{default: 0};
    chk("async_reset_main", obs_m, 0);
    chk("async_reset_short", obs_v, 0);
    chk("async_reset_frame_cnt", fc_v, 0);
    #15;
    chk("reset_held_main", obs_m, 0);
    rst_n = 1'b1;
    tick(1);
    chk("restart_hcount", hc_m, 1);
    chk("restart_short_h", hc_v, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    force dut_v.frame_cnt_q = 16'hffff;
    #1;
    release dut_v.frame_cnt_q;
    mv.fc = 65535;
`endif
    for (int i = 0; i < 8000 && !mv.fs; i++) tick(1);
    chk("second_frame_start", fs_v, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame_cnt_wrap", fc_v, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
